// File: rtl/alu_op_scheduler.sv
// alu_op_scheduler: round-robin sharing of one ALU between control unit (port 0) and fetch path (port 1).
// Define DIV_ZERO_CHECK_EN to short-circuit divide-by-zero with err=1 and an all-ones result.
module alu_op_scheduler #(
    parameter int BASIC_LAT = 2,
    parameter int MUL_LAT   = 3,
    parameter int DIV_LAT   = 4
) (
    input  logic        Clk,
    input  logic        Clear,
    input  logic [1:0]  req,
    input  logic [3:0]  op0,
    input  logic [31:0] a0,
    input  logic [31:0] b0,
    input  logic [3:0]  op1,
    input  logic [31:0] a1,
    input  logic [31:0] b1,
    output logic [1:0]  grant,
    output logic [1:0]  done,
    output logic        err,
    output logic [63:0] result,
    output logic        busy,
    output logic [31:0] alu_reg1,
    output logic [31:0] alu_reg2,
    output logic [3:0]  alu_control,
    output logic        alu_inc_pc,
    input  logic [63:0] alu_z
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        ptr_q, ptr_d, win_q, win_d, ill_q, ill_d, dz_q, dz_d;
    logic [1:0]  grant_q, grant_d, done_q, done_d;
    logic        err_q, err_d, inc_q, inc_d;
    logic [63:0] result_q, result_d;
    logic [31:0] reg1_q, reg1_d, reg2_q, reg2_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic        sel, illegal, dz;
    logic [3:0]  sel_op;
    logic [31:0] sel_a, sel_b;

    always_comb begin
        sel     = (req == 2'b11) ? ~ptr_q : req[1];
        sel_op  = sel ? op1 : op0;
        sel_a   = sel ? a1 : a0;
        sel_b   = sel ? b1 : b0;
        illegal = sel_op > 4'd12;
`ifdef DIV_ZERO_CHECK_EN
        dz      = (sel_op == 4'd0) && (sel_b == 32'd0);
`else
        dz      = 1'b0;
`endif
        state_d  = state_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        win_d    = win_q;
        ill_d    = ill_q;
        dz_d     = dz_q;
        grant_d  = 2'b00;
        done_d   = 2'b00;
        err_d    = 1'b0;
        result_d = result_q;
        reg1_d   = reg1_q;
        reg2_d   = reg2_q;
        ctrl_d   = ctrl_q;
        inc_d    = inc_q;
        case (state_q)
            IDLE: if (|req) begin
                state_d = WAIT;
                win_d   = sel;
                ptr_d   = sel;
                grant_d = sel ? 2'b10 : 2'b01;
                ill_d   = illegal;
                dz_d    = dz;
                cnt_d   = (illegal || dz)    ? 8'd1 :
                          (sel_op == 4'd0)   ? 8'(DIV_LAT) :
                          (sel_op == 4'd1)   ? 8'(MUL_LAT) : 8'(BASIC_LAT);
                // rejected ops never reach the ALU, so its drive stays as it was
                if (!(illegal || dz)) begin
                    reg1_d = sel_a;
                    reg2_d = sel_b;
                    ctrl_d = (sel_op == 4'd12) ? 4'd2 : sel_op;
                    inc_d  = sel_op == 4'd12;
                end
            end
            WAIT: if (cnt_q > 8'd1) begin
                cnt_d = cnt_q - 8'd1;
            end else begin
                cnt_d    = 8'd0;
                state_d  = DONE;
                done_d   = win_q ? 2'b10 : 2'b01;
                err_d    = ill_q | dz_q;
                result_d = ill_q ? 64'd0 : dz_q ? '1 : alu_z;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Clear) begin
        if (!Clear) begin
            state_q  <= IDLE;
            cnt_q    <= 8'd0;
            ptr_q    <= 1'b1;
            win_q    <= 1'b0;
            ill_q    <= 1'b0;
            dz_q     <= 1'b0;
            grant_q  <= 2'b00;
            done_q   <= 2'b00;
            err_q    <= 1'b0;
            result_q <= 64'd0;
            reg1_q   <= 32'd0;
            reg2_q   <= 32'd0;
            ctrl_q   <= 4'd0;
            inc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            win_q    <= win_d;
            ill_q    <= ill_d;
            dz_q     <= dz_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            err_q    <= err_d;
            result_q <= result_d;
            reg1_q   <= reg1_d;
            reg2_q   <= reg2_d;
            ctrl_q   <= ctrl_d;
            inc_q    <= inc_d;
        end
    end

    assign grant       = grant_q;
    assign done        = done_q;
    assign err         = err_q;
    assign result      = result_q;
    assign busy        = state_q != IDLE;
    assign alu_reg1    = reg1_q;
    assign alu_reg2    = reg2_q;
    assign alu_control = ctrl_q;
    assign alu_inc_pc  = inc_q;
endmodule

// File: tb/tb_alu_op_scheduler.sv
// tb_alu_op_scheduler: directed checks of arbitration, latencies, illegal ops and reset, with a small ALU model.
module tb_alu_op_scheduler;
    logic        Clk = 1'b0, Clear = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [3:0]  op0 = 4'd0, op1 = 4'd0;
    logic [31:0] a0 = 32'd0, b0 = 32'd0, a1 = 32'd0, b1 = 32'd0;
    logic [1:0]  grant, done;
    logic        err, busy, alu_inc_pc;
    logic [63:0] result, alu_z;
    logic [31:0] alu_reg1, alu_reg2;
    logic [3:0]  alu_control;
    int          n_chk = 0, n_fail = 0;

    alu_op_scheduler dut (
        .Clk(Clk), .Clear(Clear), .req(req),
        .op0(op0), .a0(a0), .b0(b0), .op1(op1), .a1(a1), .b1(b1),
        .grant(grant), .done(done), .err(err), .result(result), .busy(busy),
        .alu_reg1(alu_reg1), .alu_reg2(alu_reg2), .alu_control(alu_control),
        .alu_inc_pc(alu_inc_pc), .alu_z(alu_z)
    );

    always #5 Clk = ~Clk;

    // ALU model: divide packs {remainder, quotient}; PC increment adds one to operand 2
    always_comb begin
        alu_z = 64'd0;
        case (alu_control)
            4'd0: alu_z = (alu_reg2 == 32'd0) ? 64'd0 : {alu_reg1 % alu_reg2, alu_reg1 / alu_reg2};
            4'd1: alu_z = 64'($signed(alu_reg1)) * 64'($signed(alu_reg2));
            4'd2: alu_z = alu_inc_pc ? {32'd0, alu_reg2 + 32'd1} : {32'd0, alu_reg1 + alu_reg2};
            4'd3: alu_z = {32'd0, alu_reg1 - alu_reg2};
            default: alu_z = 64'd0;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input int p, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input logic [63:0] exp_r, input logic exp_e,
                          input logic exp_inc, input logic keep, input string tag);
        logic [1:0] oh;
        oh = (p == 0) ? 2'b01 : 2'b10;
        if (p == 0) begin op0 = op; a0 = a; b0 = b; end
        else begin op1 = op; a1 = a; b1 = b; end
        if (!keep) req[p] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge Clk);
            if (grant != 2'b00) break;
        end
        chk({tag, " grant"}, 64'(grant), 64'(oh));
        if (!keep) req[p] = 1'b0;
        chk({tag, " busy"}, 64'(busy), 64'd1);
        chk({tag, " inc_pc"}, 64'(alu_inc_pc), 64'(exp_inc));
        for (int i = 1; i < lat; i++) begin
            @(negedge Clk);
            chk({tag, " early done"}, 64'(done), 64'd0);
        end
        @(negedge Clk);
        chk({tag, " done"}, 64'(done), 64'(oh));
        chk({tag, " result"}, result, exp_r);
        chk({tag, " err"}, 64'(err), 64'(exp_e));
        chk({tag, " busy at done"}, 64'(busy), 64'd1);
        @(negedge Clk);
        chk({tag, " done pulse"}, 64'(done), 64'd0);
        chk({tag, " result hold"}, result, exp_r);
    endtask

    initial begin
        @(negedge Clk);
        chk("reset grant", 64'(grant), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset result", result, 64'd0);
        chk("reset ctrl", 64'(alu_control), 64'd0);
        Clear = 1'b1;
        @(negedge Clk);

        run_op(0, 4'd2, 32'd5, 32'd7, 2, 64'd12, 1'b0, 1'b0, 1'b0, "add");
        chk("add reg1", 64'(alu_reg1), 64'd5);
        run_op(1, 4'd14, 32'd9, 32'd9, 1, 64'd0, 1'b1, 1'b0, 1'b0, "illegal");
        chk("illegal ctrl kept", 64'(alu_control), 64'd2);
        chk("illegal reg1 kept", 64'(alu_reg1), 64'd5);
        run_op(0, 4'd1, 32'd6, 32'hFFFF_FFFD, 3, 64'hFFFF_FFFF_FFFF_FFEE, 1'b0, 1'b0, 1'b0, "mul");
        run_op(0, 4'd0, 32'd17, 32'd5, 4, 64'h0000_0002_0000_0003, 1'b0, 1'b0, 1'b0, "div");
`ifdef DIV_ZERO_CHECK_EN
        run_op(0, 4'd0, 32'd17, 32'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, "divzero");
`else
        run_op(0, 4'd0, 32'd17, 32'd0, 4, 64'd0, 1'b0, 1'b0, 1'b0, "divzero");
`endif

        op0 = 4'd2; a0 = 32'd1; b0 = 32'd2;
        op1 = 4'd12; a1 = 32'd0; b1 = 32'h100;
        req = 2'b11;
        run_op(1, 4'd12, 32'd0, 32'h100, 2, 64'h101, 1'b0, 1'b1, 1'b1, "rr1 p1");
        run_op(0, 4'd2, 32'd1, 32'd2, 2, 64'd3, 1'b0, 1'b0, 1'b1, "rr2 p0");
        run_op(1, 4'd12, 32'd0, 32'h100, 2, 64'h101, 1'b0, 1'b1, 1'b1, "rr3 p1");
        run_op(0, 4'd2, 32'd1, 32'd2, 2, 64'd3, 1'b0, 1'b0, 1'b1, "rr4 p0");
        req = 2'b00;
        @(negedge Clk);

        op0 = 4'd1; a0 = 32'd6; b0 = 32'hFFFF_FFFD;
        req = 2'b01;
        for (int k = 0; k < 6; k++) begin
            @(negedge Clk);
            if (grant != 2'b00) break;
        end
        chk("rst grant", 64'(grant), 64'd1);
        req = 2'b11;
        @(negedge Clk);
        Clear = 1'b0;
        #1;
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst result", result, 64'd0);
        chk("rst ctrl", 64'(alu_control), 64'd0);
        chk("rst reg1", 64'(alu_reg1), 64'd0);
        chk("rst inc_pc", 64'(alu_inc_pc), 64'd0);
        chk("rst grant clr", 64'(grant), 64'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            chk("rst no done", 64'(done), 64'd0);
        end
        Clear = 1'b1;
        @(negedge Clk);
        chk("post rst grant", 64'(grant), 64'd1);
        req = 2'b00;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
